// File: rtl/rotbuf_pkg.sv
// Shared frame geometry and FSM state type for the rotated frame buffer.
package rotbuf_pkg;

    localparam int FRAME_COLS   = 80;
    localparam int FRAME_ROWS   = 107;
    localparam int FRAME_PIXELS = FRAME_COLS * FRAME_ROWS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        SWAP = 2'd2
    } rotbuf_state_t;

endpackage

// File: rtl/rotated_frame_buffer_if.sv
// Write/read/status bundle between the rotation stage, the frame store and its readers.
interface rotated_frame_buffer_if #(
    parameter int ADDR_W = 17
) ();

    logic              wr_valid_in;
    logic              wr_pixel_in;
    logic [ADDR_W-1:0] wr_addr_in;
    logic              frame_start_in;
    logic              rd_en_in;
    logic [ADDR_W-1:0] rd_addr_in;
    logic              rd_pixel_out;
    logic              rd_valid_out;
    logic              frame_ready_out;
    logic              frame_drop_out;
    logic              rd_bank_out;

    modport master (
        output wr_valid_in, wr_pixel_in, wr_addr_in, frame_start_in, rd_en_in, rd_addr_in,
        input  rd_pixel_out, rd_valid_out, frame_ready_out, frame_drop_out, rd_bank_out
    );

    modport slave (
        input  wr_valid_in, wr_pixel_in, wr_addr_in, frame_start_in, rd_en_in, rd_addr_in,
        output rd_pixel_out, rd_valid_out, frame_ready_out, frame_drop_out, rd_bank_out
    );

endinterface

// File: rtl/bram_1bit_sdp.sv
// Simple dual-port 1-bit RAM: one write port, one read port with a 2-stage registered read.
module bram_1bit_sdp #(
    parameter int ADDR_W = 15
) (
    input  logic              clk_in,
    input  logic              wr_en_in,
    input  logic [ADDR_W-1:0] wr_addr_in,
    input  logic              wr_data_in,
    input  logic              rd_en_in,
    input  logic [ADDR_W-1:0] rd_addr_in,
    output logic              rd_data_out
);

    logic mem_q [0:(2**ADDR_W)-1];
    logic rdStage1_q;
    logic rdStage2_q;

    always_ff @(posedge clk_in) begin
        if (wr_en_in) begin
            mem_q[wr_addr_in] <= wr_data_in;
        end
    end

    // Contents are intentionally unreset so the array maps onto block RAM.
    always_ff @(posedge clk_in) begin
        if (rd_en_in) begin
            rdStage1_q <= mem_q[rd_addr_in];
        end
        rdStage2_q <= rdStage1_q;
    end

    assign rd_data_out = rdStage2_q;

endmodule

// File: rtl/rotated_frame_buffer.sv
// Ping-pong frame store: fills the hidden bank, swaps once a full frame has been accepted.
// Define ROTBUF_OOB_COUNT_EN to add the saturating out-of-range write counter port.
module rotated_frame_buffer #(
    parameter int ADDR_W       = 17,
    parameter int BANK_ADDR_W  = 14,
    parameter int FRAME_PIXELS = rotbuf_pkg::FRAME_PIXELS
) (
    input  logic clk_in,
    input  logic rst_in,
`ifdef ROTBUF_OOB_COUNT_EN
    output logic [15:0] oob_count_out,
`endif
    rotated_frame_buffer_if.slave bus
);
    import rotbuf_pkg::*;

    localparam int                CNT_W      = BANK_ADDR_W + 1;
    localparam logic [CNT_W-1:0]  LAST_CNT   = CNT_W'(FRAME_PIXELS - 1);
    localparam logic [CNT_W-1:0]  ONE_CNT    = CNT_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(FRAME_PIXELS);

    rotbuf_state_t    state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             rdBank_q, rdBank_d;
    logic             startHeld_q, startHeld_d;
    logic             readyPulse_q, readyPulse_d;
    logic             dropPulse_q, dropPulse_d;
    logic [1:0]       rdValidPipe_q;
    logic [1:0]       rdOobPipe_q;

    logic wrInRange;
    logic rdInRange;
    logic wrAccept;
    logic ramRdData;

    assign wrInRange = bus.wr_addr_in < ADDR_LIMIT;
    assign rdInRange = bus.rd_addr_in < ADDR_LIMIT;
    assign wrAccept  = bus.wr_valid_in && wrInRange &&
                       ((state_q == FILL) || ((state_q == IDLE) && bus.frame_start_in));

    // Completion outranks a coincident start; the start is held so SWAP resumes filling.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        rdBank_d     = rdBank_q;
        startHeld_d  = 1'b0;
        readyPulse_d = 1'b0;
        dropPulse_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.frame_start_in) begin
                    state_d = FILL;
                    count_d = wrAccept ? ONE_CNT : '0;
                end
            end
            FILL: begin
                if (wrAccept && (count_q == LAST_CNT)) begin
                    state_d      = SWAP;
                    count_d      = '0;
                    rdBank_d     = ~rdBank_q;
                    readyPulse_d = 1'b1;
                    startHeld_d  = bus.frame_start_in;
                end else if (bus.frame_start_in) begin
                    count_d     = wrAccept ? ONE_CNT : '0;
                    dropPulse_d = 1'b1;
                end else if (wrAccept) begin
                    count_d = count_q + ONE_CNT;
                end
            end
            SWAP: begin
                count_d = '0;
                state_d = (bus.frame_start_in || startHeld_q) ? FILL : IDLE;
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q      <= IDLE;
            count_q      <= '0;
            rdBank_q     <= 1'b0;
            startHeld_q  <= 1'b0;
            readyPulse_q <= 1'b0;
            dropPulse_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            rdBank_q     <= rdBank_d;
            startHeld_q  <= startHeld_d;
            readyPulse_q <= readyPulse_d;
            dropPulse_q  <= dropPulse_d;
        end
    end

    // The read bank is captured with the address, so in-flight reads survive a swap.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rdValidPipe_q <= '0;
            rdOobPipe_q   <= '0;
        end else begin
            rdValidPipe_q <= {rdValidPipe_q[0], bus.rd_en_in};
            rdOobPipe_q   <= {rdOobPipe_q[0], ~rdInRange};
        end
    end

    bram_1bit_sdp #(
        .ADDR_W(BANK_ADDR_W + 1)
    ) u_ram (
        .clk_in     (clk_in),
        .wr_en_in   (wrAccept),
        .wr_addr_in ({~rdBank_q, bus.wr_addr_in[BANK_ADDR_W-1:0]}),
        .wr_data_in (bus.wr_pixel_in),
        .rd_en_in   (bus.rd_en_in),
        .rd_addr_in ({rdBank_q, bus.rd_addr_in[BANK_ADDR_W-1:0]}),
        .rd_data_out(ramRdData)
    );

    assign bus.rd_valid_out    = rdValidPipe_q[1];
    assign bus.rd_pixel_out    = rdValidPipe_q[1] & ~rdOobPipe_q[1] & ramRdData;
    assign bus.frame_ready_out = readyPulse_q;
    assign bus.frame_drop_out  = dropPulse_q;
    assign bus.rd_bank_out     = rdBank_q;

`ifdef ROTBUF_OOB_COUNT_EN
    logic [15:0] oobCount_q;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            oobCount_q <= '0;
        end else if (bus.wr_valid_in && !wrInRange && (oobCount_q != 16'hFFFF)) begin
            oobCount_q <= oobCount_q + 16'd1;
        end
    end

    assign oob_count_out = oobCount_q;
`endif

endmodule

// File: tb/tb_rotated_frame_buffer.sv
// Bench for rotated_frame_buffer: per-cycle reference model, read table and directed frame sequences.
module tb_rotated_frame_buffer;

    localparam int ADDR_W = 17;
    localparam int FP     = 80 * 107;

    logic clk_in = 1'b0;
    logic rst_in;

    always #5 clk_in = ~clk_in;

    rotated_frame_buffer_if #(.ADDR_W(ADDR_W)) busIf ();

`ifdef ROTBUF_OOB_COUNT_EN
    logic [15:0] oobCount;
`endif

    rotated_frame_buffer dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
`ifdef ROTBUF_OOB_COUNT_EN
        .oob_count_out(oobCount),
`endif
        .bus          (busIf)
    );

    typedef struct {
        int due;
        bit care;
        bit pix;
    } rdItem_t;

    typedef struct {
        int addr;
        bit expPixel;
    } readVec_t;

    int checksTotal  = 0;
    int checksPassed = 0;
    int cycle        = 0;
    int readyCount   = 0;
    int dropCount    = 0;

    // Reference model: visible bank, per-bank pixel images and frame collection progress.
    bit  mMem   [2][FP];
    bit  mKnown [2][FP];
    bit  mBank       = 1'b0;
    bit  mCollecting = 1'b0;
    bit  mSwapping   = 1'b0;
    bit  mStartHeld  = 1'b0;
    int  mGot        = 0;
    int  oobWrites   = 0;
    bit  expReady    = 1'b0;
    bit  expDrop     = 1'b0;
    rdItem_t rdQueue[$];

    task automatic checkOutput(input string name, input int actual, input int expected);
        checksTotal++;
        if (actual != expected) begin
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycle);
        end else begin
            checksPassed++;
        end
    endtask

    task automatic modelReset();
        mBank       = 1'b0;
        mCollecting = 1'b0;
        mSwapping   = 1'b0;
        mStartHeld  = 1'b0;
        mGot        = 0;
        oobWrites   = 0;
        expReady    = 1'b0;
        expDrop     = 1'b0;
        rdQueue.delete();
    endtask

    task automatic modelStep(input bit wv, input bit pix, input int waddr,
                             input bit start, input bit ren, input int raddr);
        bit      inRange;
        rdItem_t item;
        inRange  = wv && (waddr < FP);
        expReady = 1'b0;
        expDrop  = 1'b0;
        if (wv && !inRange && oobWrites < 65535) oobWrites++;
        if (ren) begin
            item.due  = cycle + 2;
            item.care = (raddr < FP) ? mKnown[mBank][raddr] : 1'b1;
            item.pix  = (raddr < FP) ? mMem[mBank][raddr] : 1'b0;
            rdQueue.push_back(item);
        end
        if (mSwapping) begin
            mSwapping   = 1'b0;
            mCollecting = start || mStartHeld;
            mStartHeld  = 1'b0;
            mGot        = 0;
        end else if (mCollecting || start) begin
            if (inRange) begin
                mMem[!mBank][waddr]   = pix;
                mKnown[!mBank][waddr] = 1'b1;
            end
            if (mCollecting && inRange && (mGot + 1 == FP)) begin
                mBank       = !mBank;
                expReady    = 1'b1;
                mSwapping   = 1'b1;
                mStartHeld  = start;
                mCollecting = 1'b0;
                mGot        = 0;
            end else if (start) begin
                expDrop     = mCollecting;
                mCollecting = 1'b1;
                mGot        = inRange ? 1 : 0;
            end else if (inRange) begin
                mGot++;
            end
        end
    endtask

    task automatic compareCycle();
        rdItem_t item;
        checkOutput("readyPulse", int'(busIf.frame_ready_out), int'(expReady));
        checkOutput("dropPulse", int'(busIf.frame_drop_out), int'(expDrop));
        checkOutput("rdBank", int'(busIf.rd_bank_out), int'(mBank));
        if (rdQueue.size() > 0 && rdQueue[0].due == cycle) begin
            item = rdQueue.pop_front();
            checkOutput("rdValid", int'(busIf.rd_valid_out), 1);
            if (item.care) checkOutput("rdPixel", int'(busIf.rd_pixel_out), int'(item.pix));
        end else begin
            checkOutput("rdValidIdle", int'(busIf.rd_valid_out), 0);
            checkOutput("rdPixelIdle", int'(busIf.rd_pixel_out), 0);
        end
`ifdef ROTBUF_OOB_COUNT_EN
        checkOutput("oobCount", int'(oobCount), oobWrites);
`endif
    endtask

    task automatic applyStimulus(input bit wv, input bit pix, input int waddr,
                                 input bit start, input bit ren, input int raddr);
        busIf.wr_valid_in    = wv;
        busIf.wr_pixel_in    = pix;
        busIf.wr_addr_in     = waddr[ADDR_W-1:0];
        busIf.frame_start_in = start;
        busIf.rd_en_in       = ren;
        busIf.rd_addr_in     = raddr[ADDR_W-1:0];
        modelStep(wv, pix, waddr, start, ren, raddr);
        @(posedge clk_in);
        #1;
        cycle++;
        if (busIf.frame_ready_out) readyCount++;
        if (busIf.frame_drop_out) dropCount++;
        compareCycle();
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 0, 1'b0, 1'b0, 0);
    endtask

    // Reset is raised and checked between clock edges to exercise its asynchronous path.
    task automatic pulseReset();
        #3;
        rst_in = 1'b1;
        #1;
        modelReset();
        checkOutput("asyncRstReady", int'(busIf.frame_ready_out), 0);
        checkOutput("asyncRstDrop", int'(busIf.frame_drop_out), 0);
        checkOutput("asyncRstBank", int'(busIf.rd_bank_out), 0);
        checkOutput("asyncRstValid", int'(busIf.rd_valid_out), 0);
        checkOutput("asyncRstPixel", int'(busIf.rd_pixel_out), 0);
        #2;
        rst_in = 1'b0;
    endtask

    task automatic writeRange(input int first, input int last, input bit invert);
        for (int i = first; i <= last; i++) begin
            applyStimulus(1'b1, i[0] ^ invert, i, 1'b0, 1'b0, 0);
        end
    endtask

    task automatic readAt(input int addr, input bit expPix, input string tag);
        applyStimulus(1'b0, 1'b0, 0, 1'b0, 1'b1, addr);
        checkOutput({tag, "Early"}, int'(busIf.rd_valid_out), 0);
        idle();
        checkOutput({tag, "Valid"}, int'(busIf.rd_valid_out), 1);
        checkOutput({tag, "Pixel"}, int'(busIf.rd_pixel_out), int'(expPix));
    endtask

    readVec_t readTable[8];

    initial begin
        readTable[0] = '{addr: 5,      expPixel: 1'b1};
        readTable[1] = '{addr: 6,      expPixel: 1'b0};
        readTable[2] = '{addr: 0,      expPixel: 1'b0};
        readTable[3] = '{addr: 8559,   expPixel: 1'b1};
        readTable[4] = '{addr: 8558,   expPixel: 1'b0};
        readTable[5] = '{addr: 8560,   expPixel: 1'b0};
        readTable[6] = '{addr: 9000,   expPixel: 1'b0};
        readTable[7] = '{addr: 131071, expPixel: 1'b0};

        rst_in               = 1'b1;
        busIf.wr_valid_in    = 1'b0;
        busIf.wr_pixel_in    = 1'b0;
        busIf.wr_addr_in     = '0;
        busIf.frame_start_in = 1'b0;
        busIf.rd_en_in       = 1'b0;
        busIf.rd_addr_in     = '0;
        @(posedge clk_in);
        #1;
        checkOutput("resetReady", int'(busIf.frame_ready_out), 0);
        checkOutput("resetDrop", int'(busIf.frame_drop_out), 0);
        checkOutput("resetBank", int'(busIf.rd_bank_out), 0);
        checkOutput("resetValid", int'(busIf.rd_valid_out), 0);
        checkOutput("resetPixel", int'(busIf.rd_pixel_out), 0);
        #3;
        rst_in = 1'b0;

        $display("[TB] full frame");
        readyCount = 0;
        applyStimulus(1'b1, 1'b0, 0, 1'b1, 1'b0, 0);
        writeRange(1, FP - 1, 1'b0);
        checkOutput("fullReadyAfterLast", int'(busIf.frame_ready_out), 1);
        checkOutput("fullBankAfterSwap", int'(busIf.rd_bank_out), 1);
        idle();
        idle();
        checkOutput("fullReadyCount", readyCount, 1);
        foreach (readTable[k]) begin
            readAt(readTable[k].addr, readTable[k].expPixel, $sformatf("table%0d", k));
        end

        $display("[TB] drop then full frame");
        pulseReset();
        readyCount = 0;
        dropCount  = 0;
        applyStimulus(1'b1, 1'b0, 0, 1'b1, 1'b0, 0);
        writeRange(1, 99, 1'b0);
        applyStimulus(1'b0, 1'b0, 0, 1'b1, 1'b0, 0);
        checkOutput("dropPulseNow", int'(busIf.frame_drop_out), 1);
        idle();
        checkOutput("dropCount", dropCount, 1);
        checkOutput("dropNoReady", readyCount, 0);
        checkOutput("dropBankHeld", int'(busIf.rd_bank_out), 0);
        writeRange(0, FP - 1, 1'b1);
        checkOutput("afterDropBank", int'(busIf.rd_bank_out), 1);
        checkOutput("afterDropReady", readyCount, 1);
        readAt(5, 1'b0, "afterDropAddr5");

        $display("[TB] out-of-range writes");
        pulseReset();
        readyCount = 0;
        applyStimulus(1'b0, 1'b0, 0, 1'b1, 1'b0, 0);
        for (int i = 0; i < FP; i++) begin
            if (i % 171 == 10) applyStimulus(1'b1, 1'b1, 9000, 1'b0, 1'b0, 0);
            if (i == FP - 1) checkOutput("oobNoEarlyReady", readyCount, 0);
            applyStimulus(1'b1, i[0], i, 1'b0, 1'b0, 0);
        end
        checkOutput("oobReadyAtLast", int'(busIf.frame_ready_out), 1);
        readAt(9000, 1'b0, "oobAddr9000");
`ifdef ROTBUF_OOB_COUNT_EN
        checkOutput("oobCountFifty", int'(oobCount), 50);
`endif

        $display("[TB] start during swap, read across swap");
        pulseReset();
        applyStimulus(1'b0, 1'b0, 0, 1'b1, 1'b0, 0);
        writeRange(0, FP - 1, 1'b0);
        checkOutput("frameAReady", int'(busIf.frame_ready_out), 1);
        applyStimulus(1'b1, 1'b1, 0, 1'b1, 1'b0, 0);
        readyCount = 0;
        writeRange(0, FP - 2, 1'b1);
        checkOutput("frameBNoEarlyReady", readyCount, 0);
        applyStimulus(1'b1, 1'b1, FP - 1, 1'b1, 1'b1, 5);
        checkOutput("frameBReady", int'(busIf.frame_ready_out), 1);
        applyStimulus(1'b0, 1'b0, 0, 1'b0, 1'b1, 5);
        checkOutput("oldBankValid", int'(busIf.rd_valid_out), 1);
        checkOutput("oldBankPixel", int'(busIf.rd_pixel_out), 1);
        idle();
        checkOutput("newBankValid", int'(busIf.rd_valid_out), 1);
        checkOutput("newBankPixel", int'(busIf.rd_pixel_out), 0);
        writeRange(0, 2, 1'b0);
        applyStimulus(1'b0, 1'b0, 0, 1'b1, 1'b0, 0);
        checkOutput("heldStartFillDrop", int'(busIf.frame_drop_out), 1);

        $display("[TB] async reset mid-fill");
        writeRange(0, 49, 1'b0);
        applyStimulus(1'b0, 1'b0, 0, 1'b0, 1'b1, 5);
        idle();
        checkOutput("preResetValid", int'(busIf.rd_valid_out), 1);
        pulseReset();
        readyCount = 0;
        writeRange(0, 299, 1'b0);
        applyStimulus(1'b0, 1'b0, 0, 1'b1, 1'b0, 0);
        checkOutput("postResetNoDrop", int'(busIf.frame_drop_out), 0);
        writeRange(0, FP - 1, 1'b0);
        checkOutput("postResetReady", readyCount, 1);
        checkOutput("postResetBank", int'(busIf.rd_bank_out), 1);

        $display("[TB] random traffic");
        applyStimulus(1'b1, 1'b1, 3, 1'b1, 1'b0, 0);
        for (int n = 0; n < 12000; n++) begin
            applyStimulus($urandom_range(0, 19) != 0, 1'($urandom_range(0, 1)),
                          int'($urandom_range(0, 8999)), $urandom_range(0, 19999) == 0,
                          $urandom_range(0, 1) == 1, int'($urandom_range(0, 8999)));
        end
        idle();
        idle();
        idle();

        $display("[TB] %0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
